ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Pipeline register between the execute stage (ALU + condition-code register) and the memory-access stage of the 6-stage 16-bit CPU.
- Captures the ALU result, store data, destination register and control bits.
- Resolves conditional-write instructions (write-if-carry, write-if-zero) against the CCR flags.
- Exposes a registered forwarding port back to the register-read stage, and supports stall and flush from the hazard unit.

Parameters:
- DATA_W, 16, datapath width of result, store data and PC.
- REG_AW, 3, register-file address width (8 registers).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute stage holds a real instruction.
- ex_alu_result  in  DATA_W  ALU output for this instruction.
- ex_store_data  in  DATA_W  operand to be written to data memory.
- ex_pc  in  DATA_W  PC of the instruction.
- ex_dest  in  REG_AW  destination register.
- ex_reg_write  in  1  instruction writes the register file.
- ex_mem_read  in  1  load instruction.
- ex_mem_write  in  1  store instruction.
- ex_cond  in  2  00 always, 01 write only if carry=1, 10 write only if zero=1, 11 treated as 00.
- carry_flag  in  1  CCR carry output.
- zero_flag  in  1  CCR zero output.
- stall  in  1  hold the current contents.
- flush  in  1  insert a bubble.
- mem_valid  out  1  registered valid.
- mem_alu_result  out  DATA_W  registered result (memory address for load/store).
- mem_store_data  out  DATA_W  registered store data.
- mem_pc  out  DATA_W  registered PC.
- mem_dest  out  REG_AW  registered destination.
- mem_reg_write  out  1  registered, condition-resolved write enable.
- mem_mem_read  out  1  registered load flag.
- mem_mem_write  out  1  registered, condition-resolved store enable.
- fwd_en  out  1  forwarding data is usable.
- fwd_dest  out  REG_AW  forwarding register address.
- fwd_data  out  DATA_W  forwarding value.
- load_use  out  1  registered instruction is a load whose data is not yet available.

Behaviour:
- Single clock domain; all state updates on the rising edge of clock.
- Reset is synchronous and active-high: on reset every registered output is 0 (mem_valid=0, all data/PC/dest 0, all enables 0), and the optional counter is 0.
- Per-edge update priority: reset > flush > stall > load.
- flush=1: mem_valid, mem_reg_write, mem_mem_read and mem_mem_write cleared. Data, PC and dest fields may hold any value. Flush overrides a simultaneous stall.
- stall=1 (no flush): all registers hold their value. Inputs are ignored, including CCR flags.
- load (neither flush nor stall): all fields captured from ex_* with latency of 1 cycle.
- ex_valid=0 on load: captured as a bubble; all enables forced to 0.
- Condition resolution at capture, using carry_flag/zero_flag sampled in the same cycle:
  - cond_ok = (ex_cond==01) ? carry_flag : (ex_cond==10) ? zero_flag : 1.
  - mem_reg_write = ex_valid & ex_reg_write & cond_ok.
  - mem_mem_write = ex_valid & ex_mem_write & cond_ok.
  - mem_mem_read = ex_valid & ex_mem_read (unconditional).
  - A squashed conditional instruction still retires: mem_valid=1, enables 0.
- Forwarding (combinational from registered state only; no ex_* input path):
  - fwd_en = mem_valid & mem_reg_write & ~mem_mem_read.
  - fwd_dest = mem_dest.
  - fwd_data = mem_alu_result.
  - load_use = mem_valid & mem_mem_read & mem_reg_write.
- Reset asserted mid-stall or mid-flush: reset wins; the next cycle is a bubble.
- No width conversion; all data fields are pass-through at DATA_W.

Optional Feature:
- Macro: EX_MEM_SQUASH_CNT_EN.
- Defined: adds output squash_count (16 bits).
  - Increments on each load-cycle where ex_valid=1, ex_cond is 01 or 10, and cond_ok=0.
  - Saturates at 16'hFFFF.
  - Held during stall; not affected by flush; cleared only by reset.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: assert reset for 2 cycles with random inputs -> all outputs 0, fwd_en=0, load_use=0.
- Plain ALU op: ex_valid=1, ex_alu_result=16'h1234, ex_dest=3, ex_reg_write=1, ex_cond=00 -> next cycle mem_valid=1, mem_reg_write=1, fwd_en=1, fwd_dest=3, fwd_data=16'h1234.
- Conditional write: ex_cond=01 with carry_flag=0 -> mem_valid=1, mem_reg_write=0, squash_count +1 (if enabled). Repeat with carry_flag=1 -> mem_reg_write=1. ex_cond=10 with zero_flag=0 -> squashed.
- Stall/flush: load instruction A, then stall=1 for 3 cycles while changing inputs -> outputs hold A. Then stall=1 and flush=1 together -> mem_valid=0, all enables 0.
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_dest=5, ex_alu_result=16'h00F0 -> load_use=1, fwd_en=0, mem_mem_read=1, mem_alu_result=16'h00F0.
- Saturation (EX_MEM_SQUASH_CNT_EN): preload 16'hFFFE squashes -> two more squashes -> squash_count stays 16'hFFFF.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves conditional writes against the CCR and drives the forwarding port.
// Define EX_MEM_SQUASH_CNT_EN to add the saturating squash_count output.
module ex_mem_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_cond,
  input  logic              carry_flag,
  input  logic              zero_flag,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [DATA_W-1:0] mem_pc,
  output logic [REG_AW-1:0] mem_dest,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              fwd_en,
  output logic [REG_AW-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic              load_use
`ifdef EX_MEM_SQUASH_CNT_EN
  ,
  output logic [15:0]       squash_count
`endif
);

  localparam logic [1:0] COND_CARRY = 2'b01;
  localparam logic [1:0] COND_ZERO  = 2'b10;

  logic cond_ok;
  logic load_en;

  always_comb begin
    cond_ok = 1'b1;
    if (ex_cond == COND_CARRY)
      cond_ok = carry_flag;
    else if (ex_cond == COND_ZERO)
      cond_ok = zero_flag;
  end

  assign load_en = ~flush & ~stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_pc         <= '0;
      mem_dest       <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
    end else if (flush) begin
      // Bubble: only the qualifiers are cleared, data fields are don't-care.
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
    end else if (load_en) begin
      mem_valid      <= ex_valid;
      mem_alu_result <= ex_alu_result;
      mem_store_data <= ex_store_data;
      mem_pc         <= ex_pc;
      mem_dest       <= ex_dest;
      mem_reg_write  <= ex_valid & ex_reg_write & cond_ok;
      mem_mem_read   <= ex_valid & ex_mem_read;
      mem_mem_write  <= ex_valid & ex_mem_write & cond_ok;
    end
  end

  // Loads are not forwardable from here; their data arrives a stage later.
  assign fwd_en   = mem_valid & mem_reg_write & ~mem_mem_read;
  assign fwd_dest = mem_dest;
  assign fwd_data = mem_alu_result;
  assign load_use = mem_valid & mem_mem_read & mem_reg_write;

`ifdef EX_MEM_SQUASH_CNT_EN
  logic squash_hit;

  assign squash_hit = load_en & ex_valid & ~cond_ok &
                      ((ex_cond == COND_CARRY) | (ex_cond == COND_ZERO));

  always_ff @(posedge clock) begin
    if (reset)
      squash_count <= '0;
    else if (squash_hit && (squash_count != 16'hFFFF))
      squash_count <= squash_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; squash counter checks compile in with EX_MEM_SQUASH_CNT_EN.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [15:0] ex_alu_result, ex_store_data, ex_pc;
  logic [2:0]  ex_dest;
  logic [1:0]  ex_cond;
  logic        carry_flag, zero_flag, stall, flush;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, fwd_en, load_use;
  logic [15:0] mem_alu_result, mem_store_data, mem_pc, fwd_data;
  logic [2:0]  mem_dest, fwd_dest;
`ifdef EX_MEM_SQUASH_CNT_EN
  logic [15:0] squash_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clock(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_cond(ex_cond), .carry_flag(carry_flag), .zero_flag(zero_flag), .stall(stall),
    .flush(flush), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_pc(mem_pc), .mem_dest(mem_dest),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .fwd_en(fwd_en), .fwd_dest(fwd_dest),
    .fwd_data(fwd_data), .load_use(load_use)
`ifdef EX_MEM_SQUASH_CNT_EN
    , .squash_count(squash_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] pc,
                       input logic [2:0] dest, input logic rw, input logic mr,
                       input logic mw, input logic [1:0] cond);
    ex_valid = v; ex_alu_result = alu; ex_store_data = ~alu; ex_pc = pc;
    ex_dest = dest; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_cond = cond;
  endtask

  task automatic check_ctl(input string tag, input logic v, input logic rw,
                           input logic mr, input logic mw, input logic fe, input logic lu);
    check({tag, ".valid"}, 32'(mem_valid), 32'(v));
    check({tag, ".rw"}, 32'(mem_reg_write), 32'(rw));
    check({tag, ".mr"}, 32'(mem_mem_read), 32'(mr));
    check({tag, ".mw"}, 32'(mem_mem_write), 32'(mw));
    check({tag, ".fwd_en"}, 32'(fwd_en), 32'(fe));
    check({tag, ".load_use"}, 32'(load_use), 32'(lu));
  endtask

  task automatic check_sq(input string tag, input logic [15:0] exp);
`ifdef EX_MEM_SQUASH_CNT_EN
    check({tag, ".squash"}, 32'(squash_count), 32'(exp));
`else
    if (exp == 16'hDEAD) $display("unused %s", tag);
`endif
  endtask

  initial begin
    stall = 0; flush = 0; carry_flag = 1'($urandom); zero_flag = 1'($urandom);
    drive(1'b1, 16'($urandom), 16'($urandom), 3'($urandom), 1'b1, 1'($urandom), 1'b1, 2'($urandom));
    reset = 1;
    step(); step();
    check_ctl("reset", 0, 0, 0, 0, 0, 0);
    check("reset.alu", 32'(mem_alu_result), 32'h0);
    check("reset.store", 32'(mem_store_data), 32'h0);
    check("reset.pc", 32'(mem_pc), 32'h0);
    check("reset.dest", 32'(mem_dest), 32'h0);
    check_sq("reset", 16'd0);
    $display("txn reset");
    reset = 0;

    // Plain ALU op
    drive(1, 16'h1234, 16'h0010, 3'd3, 1, 0, 0, 2'b00); carry_flag = 0; zero_flag = 0;
    step();
    check_ctl("alu", 1, 1, 0, 0, 1, 0);
    check("alu.fwd_dest", 32'(fwd_dest), 32'd3);
    check("alu.fwd_data", 32'(fwd_data), 32'h1234);
    check("alu.store", 32'(mem_store_data), 32'hEDCB);
    check("alu.pc", 32'(mem_pc), 32'h0010);
    $display("txn alu result=%h dest=%0d", mem_alu_result, mem_dest);

    // Write-if-carry, carry clear -> squashed but retires
    drive(1, 16'h5555, 16'h0012, 3'd2, 1, 0, 0, 2'b01); carry_flag = 0; zero_flag = 1;
    step();
    check_ctl("wic_c0", 1, 0, 0, 0, 0, 0);
    check_sq("wic_c0", 16'd1);
    $display("txn wic carry=0");

    carry_flag = 1; zero_flag = 0;
    step();
    check_ctl("wic_c1", 1, 1, 0, 0, 1, 0);
    check_sq("wic_c1", 16'd1);
    $display("txn wic carry=1");

    // Write-if-zero store+write, zero clear -> both enables squashed
    drive(1, 16'h0040, 16'h0014, 3'd4, 1, 0, 1, 2'b10); carry_flag = 1; zero_flag = 0;
    step();
    check_ctl("wiz_z0", 1, 0, 0, 0, 0, 0);
    check_sq("wiz_z0", 16'd2);
    $display("txn wiz zero=0");

    zero_flag = 1; carry_flag = 0;
    step();
    check_ctl("wiz_z1", 1, 1, 0, 1, 1, 0);
    $display("txn wiz zero=1");

    // cond=11 behaves as always
    drive(1, 16'h0777, 16'h0016, 3'd7, 1, 0, 0, 2'b11); carry_flag = 0; zero_flag = 0;
    step();
    check_ctl("cond11", 1, 1, 0, 0, 1, 0);
    check_sq("cond11", 16'd2);
    $display("txn cond=11");

    // ex_valid=0 captured as bubble
    drive(0, 16'h0999, 16'h0018, 3'd1, 1, 1, 1, 2'b00);
    step();
    check_ctl("bubble", 0, 0, 0, 0, 0, 0);
    $display("txn bubble");

    // Load A then stall 3 cycles with changing inputs (including a would-be squash)
    drive(1, 16'hA0A0, 16'h0100, 3'd6, 1, 0, 0, 2'b00);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'(16'h1111 * (i + 1)), 16'(16'h0200 + i), 3'(i), 1, 1, 1, 2'b01);
      carry_flag = 0;
      step();
      check("stall.alu", 32'(mem_alu_result), 32'hA0A0);
      check("stall.pc", 32'(mem_pc), 32'h0100);
      check("stall.dest", 32'(mem_dest), 32'd6);
      check_ctl("stall", 1, 1, 0, 0, 1, 0);
      check_sq("stall", 16'd2);
      $display("txn stall %0d", i);
    end

    // Flush overrides stall; a squash on a flush cycle is not counted
    flush = 1;
    step();
    check_ctl("flush_stall", 0, 0, 0, 0, 0, 0);
    check_sq("flush_stall", 16'd2);
    $display("txn flush+stall");
    stall = 0; flush = 0;

    // Load-use
    drive(1, 16'h00F0, 16'h0300, 3'd5, 1, 1, 0, 2'b00);
    step();
    check_ctl("load", 1, 1, 1, 0, 0, 1);
    check("load.alu", 32'(mem_alu_result), 32'h00F0);
    check("load.dest", 32'(mem_dest), 32'd5);
    $display("txn load-use");

    // Reset during stall wins
    stall = 1; reset = 1;
    step();
    check_ctl("rst_stall", 0, 0, 0, 0, 0, 0);
    check("rst_stall.alu", 32'(mem_alu_result), 32'h0);
    check_sq("rst_stall", 16'd0);
    $display("txn reset mid-stall");
    reset = 0; stall = 0;

`ifdef EX_MEM_SQUASH_CNT_EN
    drive(1, 16'h0001, 16'h0400, 3'd1, 1, 0, 0, 2'b01); carry_flag = 0;
    repeat (65534) @(posedge clk);
    #1;
    check_sq("sat_fffe", 16'hFFFE);
    step();
    check_sq("sat_ffff", 16'hFFFF);
    step();
    check_sq("sat_hold", 16'hFFFF);
    $display("txn saturation");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
